ic_74166: RTL and testbench

- Parallel-in/serial-out shift register modelled on the 74166.
- It is the transmit end of a serial link: it loads a WIDTH-bit word in one clock and shifts it out MSB-first on Q7.
- It pairs with the serial-in/parallel-out parts (7474-based chains, 74164) for loopback benches of the chip library.
- Single clock CP with active-low clock enable and active-low parallel enable; asynchronous active-low master reset.

---
 rtl/ic_74166_cell.sv | 39 +++
 rtl/ic_74166.sv | 46 ++++
 tb/tb_ic_74166.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ic_74166_cell.sv
// One stage of the 74166 PISO shift register: 7474-style D flop with async clear.
// Latency: next state appears on q one CP edge after selection; clear is immediate.
// No backpressure: ce_n high simply holds the stored bit.
//
// Ports:
//   cp       - rising-edge clock
//   mr       - asynchronous clear, active-low
//   ce_n     - clock enable, active-low (high = hold)
//   pe_n     - parallel enable, active-low (low = load d_bit, high = take shift_in)
//   d_bit    - parallel load bit for this stage
//   shift_in - bit from the previous stage (or DS for stage 0)
//   q        - stored bit
module ic_74166_cell (
  input  logic cp,
  input  logic mr,
  input  logic ce_n,
  input  logic pe_n,
  input  logic d_bit,
  input  logic shift_in,
  output logic q
);

  logic q_nxt;

  // Hold has priority over load, and load over shift.
  always_comb begin
    q_nxt = q;
    if (!ce_n) begin
      if (!pe_n) q_nxt = d_bit;
      else       q_nxt = shift_in;
    end
  end

  always_ff @(posedge cp or negedge mr) begin
    if (!mr) q <= 1'b0;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/ic_74166.sv
// Parallel-in/serial-out shift register modelled on the 74166, MSB-first on Q7.
// Latency: loaded D[WIDTH-1] on Q7 right after the load edge; DS reaches Q7 after WIDTH shifts.
// No backpressure: CE high freezes the register, a new load discards unsent bits.
//
// Ports:
//   CP - rising-edge clock
//   MR - master reset, asynchronous, active-low
//   CE - clock enable, active-low (high = hold)
//   PE - parallel enable, active-low (low = load D, high = shift)
//   DS - serial data into stage 0
//   D  - parallel data, D[WIDTH-1] is shifted out first
//   Q7 - serial output, last stage (WIDTH must be at least 2)
module ic_74166 #(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             CE,
  input  logic             PE,
  input  logic             DS,
  input  logic [WIDTH-1:0] D,
  output logic             Q7
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] shift_in;

  // Stage i shifts in stage i-1; stage 0 takes the serial input.
  assign shift_in = {s[WIDTH-2:0], DS};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    ic_74166_cell u_cell (
      .cp       (CP),
      .mr       (MR),
      .ce_n     (CE),
      .pe_n     (PE),
      .d_bit    (D[i]),
      .shift_in (shift_in[i]),
      .q        (s[i])
    );
  end

  // Straight from the last flop, no extra output register.
  assign Q7 = s[WIDTH-1];

endmodule

// File: tb/tb_ic_74166.sv
// Directed self-checking bench for ic_74166 (WIDTH = 8).
// Inputs change 2 ns after each rising CP edge; Q7 is sampled at that same point.
// Expected Q7 values are hand-derived from the loaded words and DS streams.
module tb_ic_74166;

  localparam int WIDTH = 8;

  logic             CP = 1'b0;
  logic             MR = 1'b0;
  logic             CE = 1'b0;
  logic             PE = 1'b0;
  logic             DS = 1'b0;
  logic [WIDTH-1:0] D  = '0;
  logic             Q7;

  int n_checks = 0;
  int n_fail   = 0;

  ic_74166 #(.WIDTH(WIDTH)) dut (
    .CP (CP),
    .MR (MR),
    .CE (CE),
    .PE (PE),
    .DS (DS),
    .D  (D),
    .Q7 (Q7)
  );

  always #10 CP = ~CP;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: Q7 observed %b, expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance past one rising edge into the sampling/drive window.
  task automatic tick();
    @(posedge CP);
    #2;
  endtask

  task automatic load_word(input logic [WIDTH-1:0] w);
    CE = 1'b0;
    PE = 1'b0;
    D  = w;
    tick();
  endtask

  initial begin
    logic [3:0] ds_stream;
    logic [10:0] pass_exp;

    // Reset held low: edges with load requested must be ignored.
    MR = 1'b0; CE = 1'b0; PE = 1'b0; D = 8'hFF; DS = 1'b1;
    #1;
    check_eq("reset_initial", Q7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("reset_hold_edge%0d", i), Q7, 1'b0);
    end
    // Release between edges; the next edge performs the load.
    MR = 1'b1;
    #1;
    check_eq("reset_release", Q7, 1'b0);
    tick();
    check_eq("reset_first_load", Q7, 1'b1);

    // Load A5 then shift out MSB-first, then one draining edge.
    load_word(8'hA5);
    check_eq("a5_load", Q7, 1'b1);
    PE = 1'b1; DS = 1'b0; D = 8'h00;
    begin
      logic [6:0] a5_exp;
      a5_exp = 7'b0100101;  // bits 6..0 of A5
      for (int j = 6; j >= 0; j--) begin
        tick();
        check_eq($sformatf("a5_shift_bit%0d", j), Q7, a5_exp[j]);
      end
    end
    tick();
    check_eq("a5_drain", Q7, 1'b0);

    // Clock inhibit in the middle of C3; PE/DS/D wiggle while held.
    load_word(8'hC3);
    check_eq("c3_load", Q7, 1'b1);
    PE = 1'b1; DS = 1'b0;
    tick(); check_eq("c3_shift1", Q7, 1'b1);
    tick(); check_eq("c3_shift2", Q7, 1'b0);
    CE = 1'b1; PE = 1'b0; D = 8'hFF; DS = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("c3_hold%0d", i), Q7, 1'b0);
    end
    CE = 1'b0; PE = 1'b1; DS = 1'b0;
    begin
      logic [4:0] c3_rest;
      c3_rest = 5'b00011;   // bits 4..0 of C3
      for (int j = 4; j >= 0; j--) begin
        tick();
        check_eq($sformatf("c3_resume_bit%0d", j), Q7, c3_rest[j]);
      end
    end

    // Serial pass-through: DS 1,1,0,1 appears on Q7 from the 8th shift.
    load_word(8'h00);
    check_eq("pass_load", Q7, 1'b0);
    PE = 1'b1;
    ds_stream = 4'b1101;      // applied MSB first: 1,1,0,1
    pass_exp  = 11'b00000001101;  // Q7 after shift edges 1..11, edge 1 at MSB
    for (int e = 1; e <= 11; e++) begin
      DS = (e <= 4) ? ds_stream[4-e] : 1'b0;
      tick();
      check_eq($sformatf("pass_edge%0d", e), Q7, pass_exp[11-e]);
    end

    // Mid-stream reset: short MR pulse between edges clears at once.
    load_word(8'hFF);
    PE = 1'b1; DS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("mid_pre_shift%0d", i), Q7, 1'b1);
    end
    MR = 1'b0;
    #1;
    check_eq("mid_reset_async", Q7, 1'b0);
    #4;
    MR = 1'b1;
    #1;
    check_eq("mid_reset_released", Q7, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("mid_post_shift%0d", i), Q7, 1'b0);
    end

    // Load takes priority over an in-progress shift.
    load_word(8'hFF);
    PE = 1'b1; DS = 1'b0;
    tick(); check_eq("prio_pre1", Q7, 1'b1);
    tick(); check_eq("prio_pre2", Q7, 1'b1);
    PE = 1'b0; D = 8'h81;
    tick(); check_eq("prio_load", Q7, 1'b1);
    PE = 1'b1; D = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("prio_zero%0d", i), Q7, 1'b0);
    end
    tick(); check_eq("prio_lsb", Q7, 1'b1);
    tick(); check_eq("prio_drain", Q7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time observed %0t, expected completion before 50000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
